mem_copy_master: RTL and testbench

//  Bus initiator for the single-port word memory interface (Addr/MemEn/MemWr/WData/RdData).

---
 rtl/mem_copy_master_pkg.sv | 27 ++
 rtl/mem_copy_master.sv | 163 ++++++++++++++++
 tb/tb_mem_copy_master.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_master_pkg.sv
// Shared definitions for the word-memory copy initiator: bus widths, FSM states, request payload.
package mem_copy_master_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // One cycle of memory-side request (address, enable, direction).
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              en;
        logic              wr;
    } mem_req_t;

    // A byte address is usable only when it falls on a word boundary.
    function automatic logic is_aligned(input logic [ADDR_W-1:0] a);
        return (a & ADDR_W'(WORD_BYTES - 1)) == '0;
    endfunction

endpackage

// File: rtl/mem_copy_master.sv
// Word-memory copy initiator: copies len words from src_addr to dst_addr, 2 cycles per word.
// Optional MEMCOPY_CHECKSUM_EN adds a running modulo-2^32 sum of every written word.
module mem_copy_master
    import mem_copy_master_pkg::*;
#(
    parameter int unsigned LEN_W = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       Addr,
    output logic              MemEn,
    output logic              MemWr,
    output logic [31:0]       WData,
    input  logic [31:0]       RdData
`ifdef MEMCOPY_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    mem_req_t            req_q, req_d;
    logic                accept;

    assign accept = (state_q == S_IDLE) && start;

    // State, pointer and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
        end
    end

    // Next state and pointer updates.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    cnt_d   = len;
                    error_d = 1'b0;
                    if (!is_aligned(src_addr) || !is_aligned(dst_addr)) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                src_d   = src_q + ADDR_W'(WORD_BYTES);
                dst_d   = dst_q + ADDR_W'(WORD_BYTES);
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = (cnt_q != LEN_W'(1)) ? S_RD : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs for the coming cycle, decoded from the coming state and pointers so they register cleanly.
    always_comb begin
        req_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b0;

        case (state_d)
            S_RD: begin
                req_d.addr = src_d;
                req_d.en   = 1'b1;
                busy_d     = 1'b1;
            end
            S_WR: begin
                req_d.addr = dst_d;
                req_d.en   = 1'b1;
                req_d.wr   = 1'b1;
                busy_d     = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                req_d = '0;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
    assign Addr  = req_q.addr;
    assign MemEn = req_q.en;
    assign MemWr = req_q.wr;

    // Write data is a pass-through of the word read in the previous cycle.
    assign WData = (state_q == S_WR) ? RdData : '0;

`ifdef MEMCOPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Sum of written words; restarts on every accepted start and holds afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (state_q == S_WR) begin
            sum_q <= sum_q + RdData;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master: word memory model plus a sequential copy reference.
// Checks the checksum port too when MEMCOPY_CHECKSUM_EN is defined.
module tb_mem_copy_master;

    localparam int unsigned LEN_W = 20;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [31:0]       src_addr;
    logic [31:0]       dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       Addr;
    logic              MemEn;
    logic              MemWr;
    logic [31:0]       WData;
    logic [31:0]       RdData;
`ifdef MEMCOPY_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    mem_copy_master #(.LEN_W(LEN_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .Addr     (Addr),
        .MemEn    (MemEn),
        .MemWr    (MemWr),
        .WData    (WData),
        .RdData   (RdData)
`ifdef MEMCOPY_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Memory seen by the DUT and the bench's own expectation of it.
    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] rd_q = 32'h0;

    assign RdData = rd_q;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    endfunction

    always @(posedge clock) begin
        if (MemEn && !MemWr) rd_q <= mem_rd(Addr);
        if (MemEn && MemWr) mem[Addr[31:2]] = WData;
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        mem[a[31:2]]     = w;
        ref_mem[a[31:2]] = w;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one copy and check every cycle against the word-by-word ascending copy model.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int repulse);
        logic [31:0] words[$];
        logic [31:0] sum;
        logic [31:0] a;
        logic [31:0] w;
        logic [35:0] exp_bus;
        int          idx;
        logic        wr;
        sum = 32'h0;
        for (int i = 0; i < n; i++) begin
            w = ref_rd(s + 32'(4 * i));
            a = d + 32'(4 * i);
            ref_mem[a[31:2]] = w;
            words.push_back(w);
            sum = sum + w;
        end
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(n);
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 2 * n; c++) begin
            idx = (c - 1) / 2;
            wr  = ((c % 2) == 0);
            exp_bus = {1'b1, 1'b0, 1'b1, wr, wr ? d + 32'(4 * idx) : s + 32'(4 * idx)};
            check($sformatf("bus_c%0d", c), 64'({busy, done, MemEn, MemWr, Addr}), 64'(exp_bus));
            if (wr) check($sformatf("wdata_c%0d", c), 64'(WData), 64'(words[idx]));
            if (c == repulse) begin
                start    = 1'b1;
                src_addr = 32'h0000_0800;
                dst_addr = 32'h0000_0900;
                len      = LEN_W'(2);
            end
            tick();
            start = 1'b0;
        end
        check("done_cycle", 64'({busy, done, MemEn, error}), 64'(4'b0100));
`ifdef MEMCOPY_CHECKSUM_EN
        check("checksum_done", 64'(checksum), 64'(sum));
`endif
        tick();
        check("after_done", 64'({busy, done, MemEn}), 64'(3'b000));
`ifdef MEMCOPY_CHECKSUM_EN
        check("checksum_hold", 64'(checksum), 64'(sum));
`endif
        for (int i = 0; i <= n; i++) begin
            a = d + 32'(4 * i);
            check($sformatf("mem_%0h", a), 64'(mem_rd(a)), 64'(ref_rd(a)));
        end
    endtask

    // Start that must finish immediately without touching memory.
    task automatic run_short(input logic [31:0] s, input logic [31:0] d, input int n, input logic exp_err);
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(n);
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("short_done", 64'({busy, done, error, MemEn}), 64'({1'b0, 1'b1, exp_err, 1'b0}));
        tick();
        check("short_after", 64'({busy, done, error, MemEn}), 64'({1'b0, 1'b0, exp_err, 1'b0}));
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] d;
        int          n;

        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 32'h0;
        dst_addr = 32'h0;
        len      = '0;
        tick();
        tick();
        check("reset_flags", 64'({busy, done, error, MemEn, MemWr}), 64'(5'b00000));
        check("reset_addr", 64'(Addr), 64'h0);
        check("reset_wdata", 64'(WData), 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) preload(32'h100 + 32'(4 * i), $urandom);
        run_copy(32'h100, 32'h200, 4, 0);

        run_short(32'h100, 32'h200, 0, 1'b0);
        run_short(32'h102, 32'h200, 3, 1'b1);
        run_copy(32'h100, 32'h500, 2, 0);
        run_short(32'h100, 32'h203, 2, 1'b1);
        run_copy(32'h100, 32'h540, 1, 0);

        run_copy(32'h100, 32'h240, 4, 3);

        // Reset on cycle 5 of an 8-word copy: only words 0 and 1 land.
        for (int i = 0; i < 8; i++) preload(32'h400 + 32'(4 * i), 32'hDEAD_0000 + 32'(i));
        src_addr = 32'h100;
        dst_addr = 32'h400;
        len      = LEN_W'(8);
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        check("abort_flags", 64'({busy, done, error, MemEn, MemWr}), 64'(5'b00000));
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abort_idle_%0d", c), 64'({busy, done, MemEn}), 64'(3'b000));
        end
        ref_mem[30'(32'h400 >> 2)] = ref_rd(32'h100);
        ref_mem[30'(32'h404 >> 2)] = ref_rd(32'h104);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_mem_%0d", i), 64'(mem_rd(32'h400 + 32'(4 * i))),
                  64'(ref_rd(32'h400 + 32'(4 * i))));
        end

        preload(32'h600, 32'h0000_0001);
        preload(32'h604, 32'h0000_0002);
        preload(32'h608, 32'h0000_0003);
        preload(32'h60C, 32'hFFFF_FFFF);
        run_copy(32'h600, 32'h700, 4, 0);
`ifdef MEMCOPY_CHECKSUM_EN
        check("checksum_five", 64'(checksum), 64'h5);
`endif

        preload(32'hFFFF_FFF8, $urandom);
        preload(32'hFFFF_FFFC, $urandom);
        preload(32'h0000_0000, $urandom);
        run_copy(32'hFFFF_FFF8, 32'h300, 3, 0);

        for (int i = 0; i < 72; i++) preload(32'h1000 + 32'(4 * i), $urandom);
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 6));
            s = 32'h1000 + 32'(4 * $urandom_range(0, 60));
            d = 32'h1000 + 32'(4 * $urandom_range(0, 60));
            run_copy(s, d, n, (it % 3 == 0) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
